// File: rtl/dec_display_ctrl.sv
// Sequential binary-to-BCD display controller for a 3-digit 7-segment bank.
// Double-dabble conversion (one bit per cycle) feeds registered active-low segment outputs.
module dec_display_ctrl #(
    parameter int unsigned BLANK_LEADING = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       busy,
    output logic       done,
    output logic [9:0] bcd_out,
    output logic [6:0] dec_digit_0_out,
    output logic [6:0] dec_digit_1_out,
    output logic [6:0] dec_digit_2_out
);

    localparam bit         BlankLead    = (BLANK_LEADING != 0);
    localparam logic [6:0] SegBlank     = 7'b111_1111;
    localparam logic [6:0] SegZero      = 7'b100_0000;
    localparam logic [6:0] SegLeadReset = BlankLead ? SegBlank : SegZero;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StUpdate
    } state_e;

    state_e      state_q, state_d;
    logic [17:0] shreg_q, shreg_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [9:0]  bcd_q, bcd_d;
    logic [6:0]  seg0_q, seg0_d;
    logic [6:0]  seg1_q, seg1_d;
    logic [6:0]  seg2_q, seg2_d;
    logic        done_q, done_d;

    logic [16:0] adj;
    logic [3:0]  hund_nib;
    logic [3:0]  tens_nib;
    logic [3:0]  ones_nib;
    logic        blank_hund;
    logic        blank_tens;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b100_0000;
            4'd1:    s = 7'b111_1001;
            4'd2:    s = 7'b010_0100;
            4'd3:    s = 7'b011_0000;
            4'd4:    s = 7'b001_1001;
            4'd5:    s = 7'b001_0010;
            4'd6:    s = 7'b000_0010;
            4'd7:    s = 7'b111_1000;
            4'd8:    s = 7'b000_0000;
            4'd9:    s = 7'b001_0000;
            default: s = SegBlank;
        endcase
        return s;
    endfunction

    // Add-3 correction on the BCD field. Hundreds holds at most 1 before the final
    // shift, so it never needs correcting and bit 17 is always zero going into a shift.
    always_comb begin
        adj = shreg_q[16:0];
        if (shreg_q[11:8] >= 4'd5) begin
            adj[11:8] = shreg_q[11:8] + 4'd3;
        end
        if (shreg_q[15:12] >= 4'd5) begin
            adj[15:12] = shreg_q[15:12] + 4'd3;
        end
    end

    always_comb begin
        hund_nib   = {2'b00, shreg_q[17:16]};
        tens_nib   = shreg_q[15:12];
        ones_nib   = shreg_q[11:8];
        blank_hund = BlankLead && (hund_nib == 4'd0);
        blank_tens = blank_hund && (tens_nib == 4'd0);
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        seg0_d  = seg0_q;
        seg1_d  = seg1_q;
        seg2_d  = seg2_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    shreg_d = {10'b0, in_data};
                    cnt_d   = 3'd0;
                    state_d = StShift;
                end
            end
            StShift: begin
                shreg_d = {adj, 1'b0};
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                // All display registers load together so the digits change on one edge.
                bcd_d   = shreg_q[17:8];
                seg0_d  = seg_encode(ones_nib);
                seg1_d  = blank_tens ? SegBlank : seg_encode(tens_nib);
                seg2_d  = blank_hund ? SegBlank : seg_encode(hund_nib);
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            seg0_q  <= SegZero;
            seg1_q  <= SegLeadReset;
            seg2_q  <= SegLeadReset;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            seg0_q  <= seg0_d;
            seg1_q  <= seg1_d;
            seg2_q  <= seg2_d;
            done_q  <= done_d;
        end
    end

    assign in_ready        = (state_q == StIdle);
    assign busy            = (state_q != StIdle);
    assign done            = done_q;
    assign bcd_out         = bcd_q;
    assign dec_digit_0_out = seg0_q;
    assign dec_digit_1_out = seg1_q;
    assign dec_digit_2_out = seg2_q;

endmodule
